// File: rtl/adder_16_wide_seq.sv
// adder_16_wide_seq
// Multi-cycle wide adder sequencer. Operand words arrive LSW-first on a
// valid/ready stream; each word is pushed through an external combinational
// 16-bit adder slice, the slice carry-out is held for the next word, and every
// sum word is captured in a one-entry output register. A WORDS*16-bit add
// completes at one word per cycle using a single 16-bit adder.
module adder_16_wide_seq #(
    parameter int WORDS = 4,
    parameter int IDX_W = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_a,
    input  logic [15:0] in_b,
    input  logic        in_cin,
    output logic [15:0] add_in1,
    output logic [15:0] add_in2,
    output logic        add_cin,
    input  logic [15:0] add_sum,
    input  logic        add_cout,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_sum,
    output logic        out_last,
    output logic        out_cout,
    output logic        out_ovf,
    output logic        busy
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    // Word counter and inter-word carry.
    logic [IDX_W-1:0] word_idx_reg;
    logic             carry_reg;

    // One-entry output stage.
    logic        out_valid_reg;
    logic [15:0] out_sum_reg;
    logic        out_last_reg;
    logic        out_cout_reg;
    logic        out_ovf_reg;

    logic accept;
    logic last_word;
    logic ovf_next;

    // Word 0 takes the operation's carry-in; later words chain the stored carry.
    assign add_in1 = in_a;
    assign add_in2 = in_b;
    assign add_cin = (word_idx_reg == '0) ? in_cin : carry_reg;

    // The buffer can take a new beat whenever it is empty or draining this cycle;
    // an abort cycle never accepts.
    assign in_ready  = !clr && (!out_valid_reg || out_ready);
    assign accept    = in_valid && in_ready;
    assign last_word = (word_idx_reg == LAST_IDX);

    // Signed overflow only depends on the MSW: same-sign operands, different-sign sum.
    assign ovf_next = (in_a[15] == in_b[15]) && (add_sum[15] != in_a[15]);

    assign busy      = (word_idx_reg != '0);
    assign out_valid = out_valid_reg;
    assign out_sum   = out_sum_reg;
    assign out_last  = out_last_reg;
    assign out_cout  = out_cout_reg;
    assign out_ovf   = out_ovf_reg;

    // Word sequencing: advance per accepted beat, restart on abort or after the MSW.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_idx_reg <= '0;
            carry_reg    <= 1'b0;
        end else if (clr) begin
            word_idx_reg <= '0;
            carry_reg    <= 1'b0;
        end else if (accept) begin
            carry_reg    <= add_cout;
            word_idx_reg <= last_word ? '0 : word_idx_reg + IDX_W'(1);
        end
    end

    // Output register: load on accept, drop valid on drain, otherwise hold.
    // Abort does not touch it, so a pending word is still delivered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            out_sum_reg   <= 16'h0000;
            out_last_reg  <= 1'b0;
            out_cout_reg  <= 1'b0;
            out_ovf_reg   <= 1'b0;
        end else if (accept) begin
            out_valid_reg <= 1'b1;
            out_sum_reg   <= add_sum;
            out_last_reg  <= last_word;
            out_cout_reg  <= last_word ? add_cout : 1'b0;
            out_ovf_reg   <= last_word ? ovf_next : 1'b0;
        end else if (out_valid_reg && out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

endmodule

// File: tb/tb_adder_16_wide_seq.sv
// Bench for adder_16_wide_seq: models the external 16-bit adder slice, and
// predicts every output from whole-operand arithmetic on the words seen so far.
module tb_adder_16_wide_seq;

    localparam int WORDS = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_a = 16'h0;
    logic [15:0] in_b = 16'h0;
    logic        in_cin = 1'b0;
    logic        out_ready = 1'b0;

    logic        in_ready;
    logic [15:0] add_in1, add_in2, add_sum;
    logic        add_cin, add_cout;
    logic        out_valid, out_last, out_cout, out_ovf, busy;
    logic [15:0] out_sum;

    // External combinational adder slice.
    logic [16:0] adder_full;
    assign adder_full = {1'b0, add_in1} + {1'b0, add_in2} + {16'b0, add_cin};
    assign add_sum    = adder_full[15:0];
    assign add_cout   = adder_full[16];

    adder_16_wide_seq #(.WORDS(WORDS), .IDX_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
        .add_in1(add_in1), .add_in2(add_in2), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_last(out_last), .out_cout(out_cout), .out_ovf(out_ovf),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int n_ops = 0;

    // Model: operands of the operation in progress and the expected output register.
    logic [63:0] op_a, op_b;
    logic        op_cin;
    int          k;
    logic        m_valid, m_last, m_cout, m_ovf;
    logic [15:0] m_sum;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        k = 0; op_a = '0; op_b = '0; op_cin = 1'b0;
        m_valid = 1'b0; m_sum = 16'h0; m_last = 1'b0; m_cout = 1'b0; m_ovf = 1'b0;
    endtask

    task automatic chk_outputs();
        chk("out_valid", 64'(out_valid), 64'(m_valid));
        chk("out_sum",   64'(out_sum),   64'(m_sum));
        chk("out_last",  64'(out_last),  64'(m_last));
        chk("out_cout",  64'(out_cout),  64'(m_cout));
        chk("out_ovf",   64'(out_ovf),   64'(m_ovf));
    endtask

    // One clock: check the handshake/adder-side signals, advance the model, check outputs.
    task automatic step();
        logic [64:0] s;
        logic exp_ready, exp_cin, acc;
        #1;
        exp_ready = !clr && (!m_valid || out_ready);
        s = {1'b0, op_a} + {1'b0, op_b} + {64'b0, op_cin};
        exp_cin = (k == 0) ? in_cin : s[16*k];
        chk("in_ready", 64'(in_ready), 64'(exp_ready));
        chk("add_cin",  64'(add_cin),  64'(exp_cin));
        chk("busy",     64'(busy),     64'(k != 0));
        acc = in_valid && exp_ready;
        @(posedge clk);
        if (acc) begin
            if (k == 0) begin
                op_a = '0; op_b = '0; op_cin = in_cin;
            end
            op_a[16*k +: 16] = in_a;
            op_b[16*k +: 16] = in_b;
            s = {1'b0, op_a} + {1'b0, op_b} + {64'b0, op_cin};
            m_valid = 1'b1;
            m_sum   = s[16*k +: 16];
            m_last  = (k == WORDS - 1);
            m_cout  = m_last ? s[64] : 1'b0;
            m_ovf   = m_last ? ((op_a[63] == op_b[63]) && (s[63] != op_a[63])) : 1'b0;
            if (m_last) begin
                n_ops++;
                $display("op %0d: a=%h b=%h cin=%b -> sum=%h cout=%b ovf=%b",
                         n_ops, op_a, op_b, op_cin, s[63:0], m_cout, m_ovf);
                k = 0;
            end else begin
                k++;
            end
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
        if (clr) k = 0;
        #1;
        chk_outputs();
    endtask

    // Directed full operation with literal expectations, out_ready held high.
    task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic cin,
                          input logic cin_rest, input logic [63:0] exp_sum,
                          input logic exp_cout, input logic exp_ovf);
        out_ready = 1'b1;
        clr = 1'b0;
        for (int i = 0; i < WORDS; i++) begin
            in_valid = 1'b1;
            in_a = a[16*i +: 16];
            in_b = b[16*i +: 16];
            in_cin = (i == 0) ? cin : cin_rest;
            step();
            chk("lit_sum",  64'(out_sum),  64'(exp_sum[16*i +: 16]));
            chk("lit_last", 64'(out_last), 64'(i == WORDS - 1));
        end
        chk("lit_cout", 64'(out_cout), 64'(exp_cout));
        chk("lit_ovf",  64'(out_ovf),  64'(exp_ovf));
        in_valid = 1'b0;
        in_cin = 1'b0;
        step();
    endtask

    initial begin
        model_reset();
        #8;
        chk_outputs();
        chk("rst_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;

        // 1..4: carry chain, full wrap with carry-out, cin only on word 0, signed overflow.
        run_op(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0);
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0);
        run_op(64'h0, 64'h0, 1'b1, 1'b1, 64'h1, 1'b0, 1'b0);
        run_op(64'h7FFF_0000_0000_0000, 64'h0001_0000_0000_0000, 1'b0, 1'b0,
               64'h8000_0000_0000_0000, 1'b0, 1'b1);

        // 5: stall three cycles mid-op, then resume back-to-back.
        out_ready = 1'b1;
        in_valid = 1'b1; in_cin = 1'b0;
        in_a = 16'h4444; in_b = 16'h0404; step();
        in_a = 16'h3333; in_b = 16'h0303; step();
        out_ready = 1'b0;
        in_a = 16'h2222; in_b = 16'h0202;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_ready", 64'(in_ready), 64'd0);
            chk("stall_sum",   64'(out_sum),  64'h3636);
        end
        out_ready = 1'b1;
        step();
        chk("resume_sum", 64'(out_sum), 64'h2424);
        in_a = 16'h1111; in_b = 16'h0101; step();
        chk("resume_msw", 64'(out_sum), 64'h1212);
        in_valid = 1'b0; step();

        // 6: abort after two beats, then a fresh operation.
        in_valid = 1'b1; in_a = 16'hABCD; in_b = 16'hFFFF; in_cin = 1'b1; step();
        in_a = 16'hFFFF; in_b = 16'hFFFF; step();
        clr = 1'b1; step();
        chk("clr_busy", 64'(busy), 64'd0);
        clr = 1'b0;
        run_op(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0);

        // Randomized traffic with stalls, idles and occasional aborts.
        for (int c = 0; c < 2000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            clr       = ($urandom_range(0, 31) == 0);
            in_a      = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
            in_b      = 16'($urandom);
            in_cin    = 1'($urandom);
            step();
        end
        clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        step();

        // Async reset in the middle of an operation.
        in_valid = 1'b1; in_a = 16'h1234; in_b = 16'h8765; in_cin = 1'b0; step();
        in_a = 16'hFFFF; step();
        in_valid = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk_outputs();
        chk("rst_mid_busy", 64'(busy), 64'd0);
        #2;
        rst_n = 1'b1;
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
